wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the 8-bit pipelined processor, sitting at the far end of the memory-stage interface. Registers the memory stage's result, control and destination bus into a MEM/WB pipeline register, selects the load data or ALU/accumulator value, and commits it to a 4×8 register file. That register file serves the decode stage's two combinational read ports and drives the forwarding bus back to execute.

## Interface
Parameters:
- `DW`, 8, datapath width
- `RW`, 2, register address width (4 registers)

Ports:
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `stall`  in  1  hold MEM/WB register contents
- `flush`  in  1  load a bubble into MEM/WB
- `Wr_MEM`  in  1  instruction writes a register
- `Rm_MEM`  in  1  instruction is a load; select `data_out`
- `rdmem`  in  RW  destination register
- `acOutWb`  in  DW  ALU/accumulator result
- `data_out`  in  DW  data memory read value, valid in the same cycle as `Rm_MEM`
- `rs1`, `rs2`  in  RW  decode read addresses
- `regA`, `regB`  out  DW  read data for `rs1`/`rs2`
- `wbEn`  out  1  registered write enable (forwarding bus)
- `wbReg`  out  RW  registered destination
- `wbData`  out  DW  registered write-back value
- `wbCount`  out  8  committed-write counter

## Operation
- Selection: `res = Rm_MEM ? data_out : acOutWb`. `Rm_MEM` with `Wr_MEM`=0 is a load with no write-back and is discarded.
- MEM/WB register update on each rising `clock`, in priority order:
  1. `flush`=1: `wbEn`←0; `wbReg` and `wbData` unchanged. Flush wins over stall.
  2. Else `stall`=1: hold all fields.
  3. Else capture: `wbEn`←`Wr_MEM`, `wbReg`←`rdmem`, `wbData`←`res`.
- Register file write: at every rising edge with `wbEn`=1, `rf[wbReg]`←`wbData`.
  - A stalled, held write rewrites the same value. This is harmless.
  - All four registers are writable; no hardwired zero.
- Reads: `regA`=`rf[rs1]`, `regB`=`rf[rs2]`, combinational, subject to the bypass in Configuration.
- `wbCount` increments by 1 on each capture edge with `Wr_MEM`=1 (not stalled, not flushed). It wraps 255→0. Held or flushed cycles do not count.
- Reset (async, immediate): `wbEn`=0, `wbReg`=0, `wbData`=0, `rf[0..3]`=0, `wbCount`=0. Hence `regA`=`regB`=0 during and right after reset. On the first edge after reset deassertion, the MEM/WB register captures normally.
- Reset asserted mid-write: the pending write is lost and the register file reads zero.

## Timing
- Latency: a value presented with `Wr_MEM` at edge N appears on `wbData`/`wbEn` after edge N. It is written to the register file at edge N+1 and readable from `rf` after edge N+1.
- Forwarding bus (`wbEn`/`wbReg`/`wbData`) is valid for the whole cycle between edges N and N+1.
- Back-to-back writes to the same register: the last captured value wins. One write per cycle, no queueing.
- `stall` and `flush` are sampled only at rising `clock`. Both high in the same cycle acts as flush.

## Configuration
- `WB_BYPASS_EN` defined: same-cycle write-through on the read ports.
  - `regA`=`wbData` when `wbEn`=1 and `rs1`=`wbReg`; otherwise `rf[rs1]`. Same rule for `regB`/`rs2`.
  - Decode therefore sees a value in the cycle it is being written.
- `WB_BYPASS_EN` undefined: the read ports return `rf` contents only, so the old value is visible until edge N+1. The assembler must insert one NOP between producer and consumer.

## Structure
- Shared package `wb_pkg`: `DW`, `RW`, `NREGS`=4, reset value constant (8'h00), and a `wb_bus_t` struct {en, reg, data} used by the forwarding path in execute.
- One sub-module, `wb_regfile`:
  - 4×8 array with async reset, one write port and two combinational read ports.
  - Bypass muxes live in this sub-module, under the macro.
- `wb_stage` contains the MEM/WB register, the result mux and the counter.

## Test plan
- Reset mid-run: write `rf[2]`=8'h5A, assert `reset` between edges → `regA` (`rs1`=2) reads 8'h00 immediately; `wbEn`=0 and `wbCount`=0 with no clock edge.
- ALU write: `Wr_MEM`=1, `Rm_MEM`=0, `rdmem`=1, `acOutWb`=8'h3C → `wbData`=8'h3C after edge 1; `rf[1]`=8'h3C after edge 2; `wbCount`=1.
- Load write: `Wr_MEM`=1, `Rm_MEM`=1, `data_out`=8'hA7, `acOutWb`=8'h10, `rdmem`=3 → `rf[3]`=8'hA7. Then the same inputs with `Wr_MEM`=0 → `rf[3]` unchanged and `wbCount` does not increment.
- Stall/flush: capture 8'h11 to r0, hold `stall` for 3 cycles with new inputs 8'h22 → `wbData` stays 8'h11 and `wbCount`=1. Then `stall`=`flush`=1 → `wbEn`=0 and r0 stays 8'h11.
- Bypass: while `wbEn`=1, `wbReg`=2, `wbData`=8'hF0, `rf[2]`=8'h00, set `rs1`=2 → `regA`=8'hF0 with `WB_BYPASS_EN`, 8'h00 without it. Both builds read 8'hF0 one cycle later.
- Counter wrap: 256 consecutive captured writes → `wbCount` returns to 8'h00.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared write-back definitions: datapath sizes, reset value and the
// forwarding bus type consumed by the execute stage.
package wb_pkg;

  localparam int DW    = 8;
  localparam int RW    = 2;
  localparam int NREGS = 4;

  localparam logic [DW-1:0] RST_VAL = 8'h00;

  // Field named rd because "reg" is a reserved word.
  typedef struct packed {
    logic          en;
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } wb_bus_t;

endpackage

// File: rtl/wb_regfile.sv
// 4x8 register file: async reset, one write port, two combinational reads.
// Define WB_BYPASS_EN for same-cycle write-through on the read ports.
module wb_regfile #(
  parameter int DW = 8,
  parameter int RW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [RW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [RW-1:0] i_raddr_a,
  input  logic [RW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_a,
  output logic [DW-1:0] o_rdata_b
);
  import wb_pkg::*;

  logic [DW-1:0] r_rf [1 << RW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf <= '{default: DW'(RST_VAL)};
    end else if (i_we) begin
      r_rf[i_waddr] <= i_wdata;
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    o_rdata_a = r_rf[i_raddr_a];
    o_rdata_b = r_rf[i_raddr_b];
    if (i_we && (i_raddr_a == i_waddr)) o_rdata_a = i_wdata;
    if (i_we && (i_raddr_b == i_waddr)) o_rdata_b = i_wdata;
  end
`else
  always_comb begin
    o_rdata_a = r_rf[i_raddr_a];
    o_rdata_b = r_rf[i_raddr_b];
  end
`endif

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, result mux, commit counter and
// register file. WB_BYPASS_EN enables read-port write-through in wb_regfile.
module wb_stage #(
  parameter int DW = 8,
  parameter int RW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          Wr_MEM,
  input  logic          Rm_MEM,
  input  logic [RW-1:0] rdmem,
  input  logic [DW-1:0] acOutWb,
  input  logic [DW-1:0] data_out,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  output logic [DW-1:0] regA,
  output logic [DW-1:0] regB,
  output logic          wbEn,
  output logic [RW-1:0] wbReg,
  output logic [DW-1:0] wbData,
  output logic [7:0]    wbCount
);
  import wb_pkg::*;

  logic [DW-1:0] w_res;
  logic          r_en;
  logic [RW-1:0] r_reg;
  logic [DW-1:0] r_data;
  logic [7:0]    r_count;

  assign w_res = Rm_MEM ? data_out : acOutWb;

  // Flush only kills the enable; destination and data keep their last values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_en    <= 1'b0;
      r_reg   <= '0;
      r_data  <= DW'(RST_VAL);
      r_count <= '0;
    end else if (flush) begin
      r_en <= 1'b0;
    end else if (!stall) begin
      r_en   <= Wr_MEM;
      r_reg  <= rdmem;
      r_data <= w_res;
      if (Wr_MEM) r_count <= r_count + 8'd1;
    end
  end

  assign wbEn    = r_en;
  assign wbReg   = r_reg;
  assign wbData  = r_data;
  assign wbCount = r_count;

  wb_regfile #(
    .DW(DW),
    .RW(RW)
  ) u_regfile (
    .clk       (clock),
    .rst       (reset),
    .i_we      (r_en),
    .i_waddr   (r_reg),
    .i_wdata   (r_data),
    .i_raddr_a (rs1),
    .i_raddr_b (rs2),
    .o_rdata_a (regA),
    .o_rdata_b (regB)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; expectations follow the
// WB_BYPASS_EN setting of the build.
module tb_wb_stage;

  logic       clock = 1'b0;
  logic       reset;
  logic       stall, flush, Wr_MEM, Rm_MEM;
  logic [1:0] rdmem, rs1, rs2;
  logic [7:0] acOutWb, data_out;
  logic [7:0] regA, regB, wbData, wbCount;
  logic       wbEn;
  logic [1:0] wbReg;

  int checks = 0;
  int errors = 0;
  logic [7:0] byp_f0;
  logic [7:0] byp_3c;

  wb_stage #(.DW(8), .RW(2)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .Wr_MEM(Wr_MEM), .Rm_MEM(Rm_MEM), .rdmem(rdmem), .acOutWb(acOutWb),
    .data_out(data_out), .rs1(rs1), .rs2(rs2), .regA(regA), .regB(regB),
    .wbEn(wbEn), .wbReg(wbReg), .wbData(wbData), .wbCount(wbCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
`ifdef WB_BYPASS_EN
    byp_f0 = 8'hF0;
    byp_3c = 8'h3C;
`else
    byp_f0 = 8'h00;
    byp_3c = 8'h00;
`endif
    reset = 1'b1; stall = 1'b0; flush = 1'b0; Wr_MEM = 1'b0; Rm_MEM = 1'b0;
    rdmem = 2'd0; rs1 = 2'd0; rs2 = 2'd0; acOutWb = 8'h00; data_out = 8'h00;
    repeat (2) step();
    check("rst_wbEn", {7'd0, wbEn}, 8'h00);
    check("rst_wbCount", wbCount, 8'h00);
    check("rst_regA", regA, 8'h00);
    check("rst_regB", regB, 8'h00);
    reset = 1'b0;

    // ALU write to r1
    Wr_MEM = 1'b1; Rm_MEM = 1'b0; rdmem = 2'd1; acOutWb = 8'h3C; rs1 = 2'd1;
    step();
    check("alu_wbData", wbData, 8'h3C);
    check("alu_wbEn", {7'd0, wbEn}, 8'h01);
    check("alu_wbReg", {6'd0, wbReg}, 8'h01);
    check("alu_wbCount", wbCount, 8'h01);
    check("alu_regA_same_cycle", regA, byp_3c);
    Wr_MEM = 1'b0;
    step();
    check("alu_rf1", regA, 8'h3C);
    check("alu_wbEn_off", {7'd0, wbEn}, 8'h00);
    check("alu_wbCount_hold", wbCount, 8'h01);

    // Load write to r3
    Wr_MEM = 1'b1; Rm_MEM = 1'b1; data_out = 8'hA7; acOutWb = 8'h10; rdmem = 2'd3; rs2 = 2'd3;
    step();
    check("ld_wbData", wbData, 8'hA7);
    check("ld_wbCount", wbCount, 8'h02);
    Wr_MEM = 1'b0;
    step();
    check("ld_rf3", regB, 8'hA7);
    // Load without write-back
    data_out = 8'h55;
    step();
    check("ldnw_wbEn", {7'd0, wbEn}, 8'h00);
    check("ldnw_wbData", wbData, 8'h55);
    check("ldnw_wbCount", wbCount, 8'h02);
    step();
    check("ldnw_rf3", regB, 8'hA7);

    // Stall then stall+flush
    Wr_MEM = 1'b1; Rm_MEM = 1'b0; rdmem = 2'd0; acOutWb = 8'h11; rs1 = 2'd0;
    step();
    check("st_cap", wbData, 8'h11);
    check("st_cap_cnt", wbCount, 8'h03);
    stall = 1'b1; acOutWb = 8'h22; rdmem = 2'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_hold_data", wbData, 8'h11);
      check("st_hold_cnt", wbCount, 8'h03);
    end
    check("st_hold_reg", {6'd0, wbReg}, 8'h00);
    check("st_rf0", regA, 8'h11);
    flush = 1'b1;
    step();
    check("fl_wbEn", {7'd0, wbEn}, 8'h00);
    check("fl_wbData", wbData, 8'h11);
    check("fl_wbReg", {6'd0, wbReg}, 8'h00);
    check("fl_cnt", wbCount, 8'h03);
    step();
    check("fl_rf0", regA, 8'h11);
    check("fl_rf2", regB, 8'hA7);
    stall = 1'b0; flush = 1'b0; Wr_MEM = 1'b0;
    step();

    // Bypass visibility
    Wr_MEM = 1'b1; rdmem = 2'd2; acOutWb = 8'hF0; rs1 = 2'd2;
    step();
    Wr_MEM = 1'b0;
    check("byp_wbReg", {6'd0, wbReg}, 8'h02);
    check("byp_regA", regA, byp_f0);
    step();
    check("byp_regA_next", regA, 8'hF0);
    check("byp_cnt", wbCount, 8'h04);

    // Async reset between edges
    #2 reset = 1'b1;
    #1;
    check("mrst_regA", regA, 8'h00);
    check("mrst_wbEn", {7'd0, wbEn}, 8'h00);
    check("mrst_cnt", wbCount, 8'h00);
    step();
    reset = 1'b0;

    // Counter wrap
    Wr_MEM = 1'b1; rdmem = 2'd1; rs1 = 2'd1;
    for (int i = 0; i < 256; i++) begin
      acOutWb = 8'(i);
      step();
      if (i == 254) check("wrap_255", wbCount, 8'hFF);
    end
    check("wrap_0", wbCount, 8'h00);
    Wr_MEM = 1'b0;
    step();
    check("wrap_rf1", regA, 8'hFF);
    check("wrap_cnt_hold", wbCount, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
